// File: rtl/inst_loader.sv
// Boot-time program loader: parses a length/payload/checksum byte frame, writes
// little-endian 32-bit words to instruction memory and releases the core reset.
module inst_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        cpu_rst_o,
   output logic        done_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic [15:0] count;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [7:0]  xor_acc;
   logic [23:0] word_buf;
   logic [15:0] len_full;

   assign accept   = byte_valid_i && byte_ready_o;
   assign len_full = {byte_i, count[7:0]};

   always_ff @(posedge clk) begin
      if (rst) state <= S_LEN_LO;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept) begin
         case (state)
            S_LEN_LO: state_nxt = S_LEN_HI;
            S_LEN_HI: begin
               if (32'(len_full) > MAX_WORDS) state_nxt = S_ERR;
               else if (len_full == 16'd0)    state_nxt = S_CSUM;
               else                           state_nxt = S_DATA;
            end
            S_DATA: begin
               if (byte_idx == 2'd3 && word_idx == count - 16'd1) state_nxt = S_CSUM;
            end
            S_CSUM:  state_nxt = (byte_i == xor_acc) ? S_DONE : S_ERR;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      byte_ready_o = 1'b1;
      cpu_rst_o    = 1'b1;
      done_o       = 1'b0;
      err_o        = 1'b0;
      case (state)
         S_DONE: begin
            byte_ready_o = 1'b0;
            cpu_rst_o    = 1'b0;
            done_o       = 1'b1;
         end
         S_ERR: begin
            byte_ready_o = 1'b0;
            err_o        = 1'b1;
         end
         default: ;
      endcase
   end

   // Lanes 0..2 are buffered; the 4th byte goes straight into the write data.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         word_idx   <= '0;
         byte_idx   <= '0;
         xor_acc    <= '0;
         word_buf   <= '0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= BASE_ADDR;
         mem_data_o <= '0;
      end else begin
         mem_we_o <= 1'b0;
         if (accept) begin
            xor_acc <= xor_acc ^ byte_i;
            case (state)
               S_LEN_LO: count[7:0]  <= byte_i;
               S_LEN_HI: count[15:8] <= byte_i;
               S_DATA: begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: word_buf[7:0]   <= byte_i;
                     2'd1: word_buf[15:8]  <= byte_i;
                     2'd2: word_buf[23:16] <= byte_i;
                     default: begin
                        mem_we_o   <= 1'b1;
                        mem_data_o <= {byte_i, word_buf};
                        mem_addr_o <= BASE_ADDR + 32'({word_idx, 2'b00});
                        word_idx   <= word_idx + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: two instances (default and BASE 0x100 / MAX 4)
// see the same randomized byte stream and are checked against a frame-level model.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        byte_valid;
   logic [7:0]  byte_d;
   logic [1:0]  rdy, we, cpu, dn, er;
   logic [31:0] addr [2];
   logic [31:0] data [2];

   always #5 clk = ~clk;

   inst_loader dut0 (
      .clk(clk), .rst(rst), .byte_valid_i(byte_valid), .byte_i(byte_d),
      .byte_ready_o(rdy[0]), .mem_we_o(we[0]), .mem_addr_o(addr[0]),
      .mem_data_o(data[0]), .cpu_rst_o(cpu[0]), .done_o(dn[0]), .err_o(er[0])
   );

   inst_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4)) dut1 (
      .clk(clk), .rst(rst), .byte_valid_i(byte_valid), .byte_i(byte_d),
      .byte_ready_o(rdy[1]), .mem_we_o(we[1]), .mem_addr_o(addr[1]),
      .mem_data_o(data[1]), .cpu_rst_o(cpu[1]), .done_o(dn[1]), .err_o(er[1])
   );

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t         eq0[$], eq1[$];
   logic [7:0]  fr0[$], fr1[$];
   bit          mdone [2];
   bit          merr  [2];
   logic [31:0] base  [2];
   int          maxw  [2];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: interprets the accepted byte sequence by frame position.
   function automatic void model_step(input int i, input logic [7:0] b);
      logic [7:0] f[$];
      int         p, len;
      logic [7:0] x;
      wr_t        w;
      if (mdone[i] || merr[i]) return;
      if (i == 0) begin fr0.push_back(b); f = fr0; end
      else        begin fr1.push_back(b); f = fr1; end
      p = f.size();
      if (p < 2) return;
      len = int'({f[1], f[0]});
      if (p == 2) begin
         if (len > maxw[i]) merr[i] = 1'b1;
         return;
      end
      if (p <= 2 + 4 * len) begin
         if ((p - 2) % 4 == 0) begin
            w.a = base[i] + 32'(4 * ((p - 2) / 4 - 1));
            w.d = {f[p-1], f[p-2], f[p-3], f[p-4]};
            if (i == 0) eq0.push_back(w);
            else        eq1.push_back(w);
         end
      end else begin
         x = 8'h00;
         for (int k = 0; k < p - 1; k++) x ^= f[k];
         if (x == f[p-1]) mdone[i] = 1'b1;
         else             merr[i]  = 1'b1;
      end
   endfunction

   function automatic void model_reset();
      fr0.delete(); fr1.delete(); eq0.delete(); eq1.delete();
      for (int i = 0; i < 2; i++) begin
         mdone[i] = 1'b0;
         merr[i]  = 1'b0;
      end
   endfunction

   task automatic mon(input int i);
      wr_t w;
      bit  have;
      have = 1'b0;
      if (i == 0 && eq0.size() > 0) begin w = eq0.pop_front(); have = 1'b1; end
      if (i == 1 && eq1.size() > 0) begin w = eq1.pop_front(); have = 1'b1; end
      if (have) begin
         chk($sformatf("we%0d", i),   32'(we[i]), 32'd1);
         chk($sformatf("addr%0d", i), addr[i], w.a);
         chk($sformatf("data%0d", i), data[i], w.d);
      end else if (we[i]) begin
         chk($sformatf("unexpected_we%0d", i), 32'(we[i]), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0);
         mon(1);
      end
   end

   task automatic check_status(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_ready%0d", tag, i), 32'(rdy[i]), 32'(!(mdone[i] || merr[i])));
         chk($sformatf("%s_done%0d", tag, i),  32'(dn[i]),  32'(mdone[i]));
         chk($sformatf("%s_err%0d", tag, i),   32'(er[i]),  32'(merr[i]));
         chk($sformatf("%s_cpurst%0d", tag, i), 32'(cpu[i]), 32'(!mdone[i]));
      end
   endtask

   // Called at a negedge; returns at a negedge.
   task automatic send(input logic [7:0] b, input int gap);
      byte_valid = 1'b1;
      byte_d     = b;
      @(posedge clk);
      model_step(0, b);
      model_step(1, b);
      @(negedge clk);
      byte_valid = 1'b0;
      byte_d     = 8'($urandom);
      check_status("byte");
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset(input bit with_byte);
      rst        = 1'b1;
      byte_valid = with_byte;
      byte_d     = 8'h55;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst        = 1'b0;
      byte_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
         chk($sformatf("rst_we%0d", i),    32'(we[i]),  32'd0);
         chk($sformatf("rst_addr%0d", i),  addr[i],     base[i]);
         chk($sformatf("rst_data%0d", i),  data[i],     32'd0);
         chk($sformatf("rst_cpurst%0d", i), 32'(cpu[i]), 32'd1);
         chk($sformatf("rst_done%0d", i),  32'(dn[i]),  32'd0);
         chk($sformatf("rst_err%0d", i),   32'(er[i]),  32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s1 [7];
      logic [7:0] p2 [8];
      logic [7:0] fr [$];
      logic [7:0] x;
      int         len;

      base[0] = 32'h0000_0000; maxw[0] = 1024;
      base[1] = 32'h0000_0100; maxw[1] = 4;
      s1 = '{8'h01, 8'h00, 8'h20, 8'h00, 8'h01, 8'h34, 8'h14};
      p2 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      rst = 1'b0; byte_valid = 1'b0; byte_d = 8'h00;
      @(negedge clk);
      do_reset(1'b0);

      // single word, back to back, then terminal hold
      for (int k = 0; k < 7; k++) send(s1[k], 0);
      chk("single_done", 32'(dn[0]), 32'd1);
      chk("single_cpurst", 32'(cpu[0]), 32'd0);
      for (int k = 0; k < 20; k++) send(8'($urandom), 0);
      chk("hold_done", 32'(dn[0]), 32'd1);

      // two words with idle gaps
      do_reset(1'b0);
      x = 8'h02;
      send(8'h02, int'($urandom_range(1, 3)));
      send(8'h00, int'($urandom_range(1, 3)));
      for (int k = 0; k < 8; k++) begin
         x ^= p2[k];
         send(p2[k], int'($urandom_range(1, 3)));
      end
      send(x, 1);
      chk("two_done", 32'(dn[1]), 32'd1);

      // bad checksum, then ignored bytes
      do_reset(1'b0);
      for (int k = 0; k < 6; k++) send(s1[k], 0);
      send(8'h15, 0);
      chk("badcs_err", 32'(er[0]), 32'd1);
      for (int k = 0; k < 5; k++) send(8'($urandom), 0);

      // oversize count for the MAX_WORDS=4 instance
      do_reset(1'b0);
      send(8'h05, 0);
      send(8'h00, 0);
      chk("oversize_err", 32'(er[1]), 32'd1);
      for (int k = 0; k < 21; k++) send(8'($urandom), 0);

      // zero count
      do_reset(1'b0);
      send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      chk("zero_done", 32'(dn[0]), 32'd1);

      // mid-frame reset (with a byte offered during rst), then full frame
      do_reset(1'b0);
      for (int k = 0; k < 4; k++) send(s1[k], 0);
      do_reset(1'b1);
      for (int k = 0; k < 7; k++) send(s1[k], 0);
      chk("after_rst_done", 32'(dn[0]), 32'd1);

      // random frames, occasionally corrupted
      for (int n = 0; n < 10; n++) begin
         do_reset(1'b0);
         len = int'($urandom_range(0, 6));
         fr.delete();
         fr.push_back(8'(len));
         fr.push_back(8'h00);
         for (int k = 0; k < 4 * len; k++) fr.push_back(8'($urandom));
         x = 8'h00;
         foreach (fr[k]) x ^= fr[k];
         if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
         fr.push_back(x);
         foreach (fr[k]) send(fr[k], int'($urandom_range(0, 2)));
         repeat (2) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("queue0_empty", 32'(eq0.size()), 32'd0);
      chk("queue1_empty", 32'(eq1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
